alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU (AND/OR/ADD/SUB/NOR plus beq/blt branch compare) between two requesters, e.g. the integer issue path (port 0) and the branch/address unit (port 1).
- Uses round-robin arbitration with valid/ready handshakes on the request side and one registered, backpressurable response channel tagged with the requester id.
- Sits between the decode/issue logic and the writeback/branch-resolve logic.

Parameters:
- DATA_W, 64, operand/result width
- TAG_W, 4, opaque requester tag carried through to the response
- CNT_W, 16, width of the grant counters (optional feature only)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  DATA_W  operand a
- req0_b  in  DATA_W  operand b
- req0_alu_op  in  4  ALU opcode
- req0_br_op  in  1  0=beq, 1=blt
- req0_tag  in  TAG_W  tag
- req1_valid, req1_ready, req1_a, req1_b, req1_alu_op, req1_br_op, req1_tag: same as port 0, for requester 1
- resp_valid  out  1  response held in the output register
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  requester that issued the response
- resp_tag  out  TAG_W  tag of the issuing request
- resp_result  out  DATA_W  ALU result
- resp_branch  out  1  branch-taken flag

Behaviour:
- Reset (async assert, sync release): resp_valid=0, resp_result=0, resp_branch=0, resp_id=0, resp_tag=0, rr_ptr=0 (port 0 favoured first). A response in flight at reset is dropped and not replayed.
- ALU opcodes:
  - 0000 AND, 0001 OR, 0010 ADD (mod 2^DATA_W, carry dropped), 0110 SUB (mod 2^DATA_W), 1100 NOR.
  - Any other opcode: result=0, no latch, no error.
- Branch flag:
  - br_op=0: branch = (result==0).
  - br_op=1: branch = (a<b) as an unsigned compare, independent of alu_op.
- slot_free = !resp_valid || resp_ready.
- Grant (combinational):
  - Only one valid: that port is granted.
  - Both valid: port rr_ptr is granted.
  - req_ready = grant && slot_free. At most one ready is high per cycle.
- Transfer occurs when valid && ready. On transfer, the ALU output, id and tag are registered. resp_valid=1 on the next edge, so latency is exactly 1 cycle.
- rr_ptr updates only on a transfer, to the port not granted. There is no update on idle or stalled cycles.
- Output state machine, two states:
  - EMPTY (resp_valid=0): a transfer moves it to FULL.
  - FULL, resp_ready=1, transfer: stay FULL with new contents (back-to-back throughput, 1 op/cycle).
  - FULL, resp_ready=1, no transfer: go to EMPTY.
  - FULL, resp_ready=0: hold. All resp_* are stable and both readies are low.
- Requester rules: a, b, op and tag are held stable while valid=1 and ready=0. Valid must not depend on ready. Ready may depend on valid.
- Fairness: with both ports continuously valid and resp_ready=1, grants alternate 0,1,0,1,...
- Starvation bound: a waiting port is granted within 2 transfers.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs stat_grant0 and stat_grant1 (CNT_W each).
  - Each counter increments on every transfer from its port and saturates at all-ones.
  - Adds input stat_clr (1); when high, it synchronously zeroes both counters and wins over a same-cycle increment.
  - Counters reset to 0.
- Without the macro: these ports and counters do not exist. The rest of the behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_NOR=4'b1100.
  - BR_BEQ=1'b0, BR_BLT=1'b1.
  - Typedef alu_req_t (a, b, alu_op, br_op, tag) and typedef req_id_t.
- Sub-module alu_core: purely combinational, containing the ALU and branch compare. The arbiter instantiates it once, on the muxed granted request.

Test Plan:
- Port 0 only: ADD a=5, b=7, tag=3 -> next cycle resp_valid=1, result=12, id=0, tag=3, branch=0.
- Port 1 only: SUB a=9, b=9, beq -> result=0, branch=1. Then SUB a=0, b=1, blt -> result=0xFFFF_FFFF_FFFF_FFFF, branch=1.
- Both ports valid for 4 cycles with resp_ready=1 -> grants in order 0,1,0,1, one response per cycle, tags in matching order.
- Stall: resp_ready=0 for 3 cycles while holding a result -> resp_* stable and both readies low. When released, resp_ready=1 is accepted together with a new transfer in the same cycle.
- Opcode 4'b1111 with a=0xFF, b=0x0F -> result=0. NOR of a=0, b=0 -> all-ones.
- rst_n asserted asynchronously with resp_valid=1 -> all outputs go to 0 immediately and rr_ptr=0. With ALU_ARB_STATS_EN: counters go to 0, and stat_clr given together with a transfer yields 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   - ALU opcode and branch-op constants
//   - Default operand/tag widths and the request bundle type
//   - Output-slot state encoding
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 64;
  localparam int unsigned ALU_TAG_W  = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BLT = 1'b1;

  // Requester index: 0 = issue path, 1 = branch/address unit.
  typedef logic req_id_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [3:0]            alu_op;
    logic                  br_op;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_req_t;

  // Output register occupancy.
  typedef enum logic {StEmpty, StFull} out_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 64-bit ALU with branch compare.
// Ports:
//   a, b     : operands
//   alu_op   : AND/OR/ADD/SUB/NOR; any other code yields zero
//   br_op    : 0 = beq (result == 0), 1 = blt (unsigned a < b)
//   result   : ALU result
//   branch   : branch-taken flag
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_op,
  input  logic              br_op,
  output logic [DATA_W-1:0] result,
  output logic              branch
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  // blt ignores the opcode entirely and compares the raw operands.
  always_comb begin
    branch = 1'b0;
    if (br_op == BR_BLT) begin
      branch = (a < b);
    end else begin
      branch = (result == '0);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu_core between two requesters, with a
// single registered, backpressurable response slot tagged by requester id.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   reqN_valid/ready      : request handshake for port N (0, 1)
//   reqN_a/b/alu_op/br_op : operation for port N
//   reqN_tag              : opaque tag returned with the response
//   resp_valid/ready      : response handshake
//   resp_id/tag/result/branch : response contents
// Optional build macro ALU_ARB_STATS_EN adds per-port saturating grant
// counters (stat_grant0/1, CNT_W wide) and a synchronous clear (stat_clr).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned TAG_W  = ALU_TAG_W
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_alu_op,
  input  logic              req0_br_op,
  input  logic [TAG_W-1:0]  req0_tag,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_alu_op,
  input  logic              req1_br_op,
  input  logic [TAG_W-1:0]  req1_tag,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_branch
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_grant0,
  output logic [CNT_W-1:0]  stat_grant1
`endif
);

  out_state_e state_q, state_d;
  req_id_t    rr_ptr_q, rr_ptr_d;
  req_id_t    gnt_id;
  logic       slot_free;
  logic       xfer;

  logic [DATA_W-1:0] sel_a, sel_b;
  logic [3:0]        sel_alu_op;
  logic              sel_br_op;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;

  logic              resp_id_q;
  logic [TAG_W-1:0]  resp_tag_q;
  logic [DATA_W-1:0] resp_result_q;
  logic              resp_branch_q;

  // The slot accepts a new op when empty or when its occupant leaves this cycle.
  assign slot_free = (state_q == StEmpty) || resp_ready;

  // A lone valid wins outright; on contention rr_ptr_q picks.
  always_comb begin
    gnt_id = rr_ptr_q;
    if (req0_valid && !req1_valid) begin
      gnt_id = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign xfer       = (req0_valid || req1_valid) && slot_free;
  assign req0_ready = xfer && (gnt_id == 1'b0);
  assign req1_ready = xfer && (gnt_id == 1'b1);

  assign sel_a      = gnt_id ? req1_a      : req0_a;
  assign sel_b      = gnt_id ? req1_b      : req0_b;
  assign sel_alu_op = gnt_id ? req1_alu_op : req0_alu_op;
  assign sel_br_op  = gnt_id ? req1_br_op  : req0_br_op;
  assign sel_tag    = gnt_id ? req1_tag    : req0_tag;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .a      (sel_a),
    .b      (sel_b),
    .alu_op (sel_alu_op),
    .br_op  (sel_br_op),
    .result (alu_result),
    .branch (alu_branch)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull:  if (resp_ready && !xfer) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    // Pointer moves only on a real transfer, to the port that lost.
    if (xfer) begin
      rr_ptr_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id_q     <= 1'b0;
      resp_tag_q    <= '0;
      resp_result_q <= '0;
      resp_branch_q <= 1'b0;
    end else if (xfer) begin
      resp_id_q     <= gnt_id;
      resp_tag_q    <= sel_tag;
      resp_result_q <= alu_result;
      resp_branch_q <= alu_branch;
    end
  end

  assign resp_valid  = (state_q == StFull);
  assign resp_id     = resp_id_q;
  assign resp_tag    = resp_tag_q;
  assign resp_result = resp_result_q;
  assign resp_branch = resp_branch_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_q, grant0_d;
  logic [CNT_W-1:0] grant1_q, grant1_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    if (stat_clr) begin
      grant0_d = '0;
      grant1_d = '0;
    end else begin
      if (req0_ready && req0_valid && (grant0_q != '1)) grant0_d = grant0_q + 1'b1;
      if (req1_ready && req1_valid && (grant1_q != '1)) grant1_d = grant1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_q <= '0;
      grant1_q <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
    end
  end

  assign stat_grant0 = grant0_q;
  assign stat_grant1 = grant1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases plus randomized
// traffic, with a queue-based scoreboard and an independent output monitor.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned DW = ALU_DATA_W;
  localparam int unsigned TW = ALU_TAG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] v = 2'b00;
  alu_req_t rq [2];
  logic resp_ready = 1'b1;
  logic req0_ready, req1_ready;
  logic resp_valid, resp_id, resp_branch;
  logic [TW-1:0] resp_tag;
  logic [DW-1:0] resp_result;
`ifdef ALU_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [15:0] stat_grant0, stat_grant1;
  int m_cnt [2];
`endif

  typedef struct {
    logic          id;
    logic [TW-1:0] tag;
    logic [DW-1:0] result;
    logic          branch;
  } exp_t;

  exp_t q [$];
  int total = 0;
  int bad = 0;
  logic m_full = 1'b0;
  logic m_rr = 1'b0;
  logic [1:0] pend = 2'b00;
  logic sx, sg;

  always #5 clk = ~clk;

  alu_share_arbiter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (v[0]),
    .req0_ready  (req0_ready),
    .req0_a      (rq[0].a),
    .req0_b      (rq[0].b),
    .req0_alu_op (rq[0].alu_op),
    .req0_br_op  (rq[0].br_op),
    .req0_tag    (rq[0].tag),
    .req1_valid  (v[1]),
    .req1_ready  (req1_ready),
    .req1_a      (rq[1].a),
    .req1_b      (rq[1].b),
    .req1_alu_op (rq[1].alu_op),
    .req1_br_op  (rq[1].br_op),
    .req1_tag    (rq[1].tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_tag    (resp_tag),
    .resp_result (resp_result),
    .resp_branch (resp_branch)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ALU semantics straight from the opcode table.
  function automatic exp_t ref_op(input alu_req_t r, input logic id);
    exp_t e;
    logic [DW-1:0] res;
    case (r.alu_op)
      4'b0000: res = r.a & r.b;
      4'b0001: res = r.a | r.b;
      4'b0010: res = r.a + r.b;
      4'b0110: res = r.a - r.b;
      4'b1100: res = ~(r.a | r.b);
      default: res = '0;
    endcase
    e.id = id;
    e.tag = r.tag;
    e.result = res;
    e.branch = r.br_op ? (r.a < r.b) : (res == '0);
    return e;
  endfunction

  task automatic set_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] op, input logic br, input logic [TW-1:0] tag);
    rq[p].a = a;
    rq[p].b = b;
    rq[p].alu_op = op;
    rq[p].br_op = br;
    rq[p].tag = tag;
  endtask

  // One clock cycle: drive, predict grant, check readies, push expectation.
  // Entered and left just after a rising edge.
  task automatic step(input logic [1:0] nv, input logic nr, output logic xfer, output logic g);
    logic slot;
    v = nv;
    resp_ready = nr;
    #1;
    slot = !m_full || resp_ready;
    g = (v == 2'b11) ? m_rr : v[1];
    xfer = (v != 2'b00) && slot;
    chk("req0_ready", req0_ready, xfer && !g);
    chk("req1_ready", req1_ready, xfer && g);
    if (xfer) begin
      q.push_back(ref_op(rq[g], g));
      m_rr = !g;
    end
    @(posedge clk);
    #1;
    m_full = xfer || (m_full && !nr);
    chk("resp_valid", resp_valid, m_full);
`ifdef ALU_ARB_STATS_EN
    if (stat_clr) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else if (xfer && m_cnt[g] < 65535) begin
      m_cnt[g]++;
    end
    chk("stat_grant0", stat_grant0, m_cnt[0]);
    chk("stat_grant1", stat_grant1, m_cnt[1]);
`endif
  endtask

  // Monitor: whenever a response is presented, it must match the oldest
  // expectation; it retires once the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (q.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        chk("resp_id", resp_id, q[0].id);
        chk("resp_tag", resp_tag, q[0].tag);
        chk("resp_result", resp_result, q[0].result);
        chk("resp_branch", resp_branch, q[0].branch);
        if (resp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic x, g;
    logic [DW-1:0] ra, rb;
    set_req(0, '0, '0, 4'h0, 1'b0, '0);
    set_req(1, '0, '0, 4'h0, 1'b0, '0);
`ifdef ALU_ARB_STATS_EN
    m_cnt[0] = 0;
    m_cnt[1] = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_branch", resp_branch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Port 0 ADD 5+7.
    set_req(0, 64'd5, 64'd7, ALU_ADD, BR_BEQ, 4'd3);
    step(2'b01, 1'b1, x, g);
    chk("add_result_direct", resp_result, 64'd12);
    step(2'b00, 1'b1, x, g);

    // Port 1 SUB beq then blt.
    set_req(1, 64'd9, 64'd9, ALU_SUB, BR_BEQ, 4'd5);
    step(2'b10, 1'b1, x, g);
    chk("sub_beq_branch", resp_branch, 1);
    set_req(1, 64'd0, 64'd1, ALU_SUB, BR_BLT, 4'd6);
    step(2'b10, 1'b1, x, g);
    chk("sub_blt_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
    step(2'b00, 1'b1, x, g);

    // Both ports contend: expect 0,1,0,1.
    set_req(0, 64'd1, 64'd2, ALU_OR, BR_BEQ, 4'd0);
    set_req(1, 64'd3, 64'd4, ALU_AND, BR_BLT, 4'd8);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b1, x, g);
      chk("rr_order", g, i % 2);
      set_req(int'(g), DW'(i + 10), DW'(i), ALU_ADD, BR_BEQ, TW'(i + (g ? 8 : 0) + 1));
    end
    step(2'b00, 1'b1, x, g);

    // Stall three cycles with both ports pending, then release with a transfer.
    set_req(0, 64'hA, 64'h3, ALU_SUB, BR_BEQ, 4'd1);
    step(2'b01, 1'b1, x, g);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, x, g);
    step(2'b11, 1'b1, x, g);
    chk("stall_release_xfer", x, 1);
    step(2'b00, 1'b1, x, g);
    step(2'b00, 1'b1, x, g);

    // Illegal opcode and NOR of zeros.
    set_req(0, 64'hFF, 64'h0F, 4'b1111, BR_BLT, 4'd2);
    step(2'b01, 1'b1, x, g);
    chk("illegal_op_result", resp_result, 0);
    set_req(0, 64'h0, 64'h0, ALU_NOR, BR_BEQ, 4'd4);
    step(2'b01, 1'b1, x, g);
    chk("nor_zero_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Async reset while holding a response.
    set_req(1, 64'h7, 64'h7, ALU_ADD, BR_BEQ, 4'd9);
    step(2'b10, 1'b0, x, g);
    v = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_result", resp_result, 0);
    chk("arst_resp_id", resp_id, 0);
    chk("arst_resp_tag", resp_tag, 0);
    chk("arst_resp_branch", resp_branch, 0);
`ifdef ALU_ARB_STATS_EN
    chk("arst_stat0", stat_grant0, 0);
    chk("arst_stat1", stat_grant1, 0);
    m_cnt[0] = 0;
    m_cnt[1] = 0;
`endif
    q.delete();
    m_full = 1'b0;
    m_rr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b11, 1'b1, x, g);
    chk("post_rst_rr", g, 0);
    step(2'b00, 1'b1, x, g);

`ifdef ALU_ARB_STATS_EN
    set_req(0, 64'd1, 64'd1, ALU_ADD, BR_BEQ, 4'd1);
    step(2'b01, 1'b1, x, g);
    stat_clr = 1'b1;
    step(2'b01, 1'b1, x, g);
    stat_clr = 1'b0;
    chk("clr_with_xfer", stat_grant0, 0);
`endif

    // Randomized traffic with held requests and random backpressure.
    pend = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 3) == 0) begin
            ra = DW'($urandom_range(0, 3));
            rb = DW'($urandom_range(0, 3));
          end else begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
          end
          set_req(p, ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  TW'($urandom_range(0, 15)));
          pend[p] = 1'b1;
        end
      end
`ifdef ALU_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 31) == 0);
`endif
      step(pend, ($urandom_range(0, 3) != 0), sx, sg);
      if (sx) pend[sg] = 1'b0;
    end
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Drain and confirm nothing is left outstanding.
    step(2'b00, 1'b1, x, g);
    step(2'b00, 1'b1, x, g);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
